// File: rtl/id_decode_pipe.sv
// id_decode_pipe
//
// Decode stage with its own ID/EX pipeline register. Holds the register bank,
// which has a write-first bypass from the writeback port. Also holds the
// immediate extender, jump/branch target generation and in-stage branch
// resolution. Load-use and branch-operand hazards are detected here and
// resolved by stalling IF/ID while a bubble goes into ID/EX.
//
// Ports
//   i_clk, i_reset          clock; synchronous active-low reset
//   i_step                  advance enable; 0 freezes ID/EX and the stall
//                           counter, but WB writes still land in the bank
//   i_valid, i_instr, i_pc4 instruction from IF/ID
//   i_ext_mode              0 sign, 1 zero, 2 upper, 3 sign<<2
//   i_ctrl_*                decoded control bits
//   i_flush                 turn the instruction entering ID/EX into a bubble
//   i_wb_*                  writeback port
//   i_debug_addr/o_debug_data  combinational bank read (same bypass rule)
//   o_stall                 hold PC and IF/ID this cycle
//   o_branch_taken/o_branch_target/o_jump_target  combinational
//   o_ex_*                  registered ID/EX contents
//   o_stall_count           saturating count of stalled step cycles
//
// Handshake: no valid/ready pair. i_valid qualifies IF/ID; o_stall tells the
// front end to hold that same instruction for the next cycle.
module id_decode_pipe #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_JUMP      = 26,
  parameter int BITS_REGS      = 5,
  parameter int REG_SIZE       = 32,
  parameter int BITS_INMEDIATE = 16,
  parameter int BITS_STALLCNT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic                     i_valid,
  input  logic [BITS_SIZE-1:0]     i_instr,
  input  logic [BITS_SIZE-1:0]     i_pc4,
  input  logic [1:0]               i_ext_mode,
  input  logic                     i_ctrl_mem_read,
  input  logic                     i_ctrl_reg_write,
  input  logic                     i_ctrl_reg_dst,
  input  logic                     i_ctrl_beq,
  input  logic                     i_ctrl_bne,
  input  logic                     i_flush,
  input  logic                     i_wb_reg_write,
  input  logic [BITS_REGS-1:0]     i_wb_addr_rd,
  input  logic [BITS_SIZE-1:0]     i_wb_data,
  input  logic [BITS_REGS-1:0]     i_debug_addr,
  output logic [BITS_SIZE-1:0]     o_debug_data,
  output logic                     o_stall,
  output logic                     o_branch_taken,
  output logic [BITS_SIZE-1:0]     o_branch_target,
  output logic [BITS_SIZE-1:0]     o_jump_target,
  output logic                     o_ex_valid,
  output logic                     o_ex_mem_read,
  output logic                     o_ex_reg_write,
  output logic [BITS_SIZE-1:0]     o_ex_rs_data,
  output logic [BITS_SIZE-1:0]     o_ex_rt_data,
  output logic [BITS_SIZE-1:0]     o_ex_imm,
  output logic [BITS_SIZE-1:0]     o_ex_pc4,
  output logic [BITS_REGS-1:0]     o_ex_rs,
  output logic [BITS_REGS-1:0]     o_ex_rt,
  output logic [BITS_REGS-1:0]     o_ex_rd,
  output logic [BITS_STALLCNT-1:0] o_stall_count
);

  localparam int EXT_W   = BITS_SIZE - BITS_INMEDIATE;
  localparam int PC_HI_W = BITS_SIZE - BITS_JUMP - 2;

  typedef struct packed {
    logic                 valid;
    logic                 mem_read;
    logic                 reg_write;
    logic [BITS_SIZE-1:0] rs_data;
    logic [BITS_SIZE-1:0] rt_data;
    logic [BITS_SIZE-1:0] imm;
    logic [BITS_SIZE-1:0] pc4;
    logic [BITS_REGS-1:0] rs;
    logic [BITS_REGS-1:0] rt;
    logic [BITS_REGS-1:0] rd;
  } ex_t;

  logic [BITS_SIZE-1:0]     regs_q [REG_SIZE];
  ex_t                      ex_q, ex_d;
  logic [BITS_STALLCNT-1:0] stall_cnt_q, stall_cnt_d;

  // Instruction fields
  logic [BITS_REGS-1:0]      rs, rt, rd;
  logic [BITS_INMEDIATE-1:0] imm;
  logic [BITS_JUMP-1:0]      target;
  logic                      unused_opcode;

  assign rs     = i_instr[BITS_JUMP-1 -: BITS_REGS];
  assign rt     = i_instr[BITS_JUMP-1-BITS_REGS -: BITS_REGS];
  assign rd     = i_instr[BITS_INMEDIATE-1 -: BITS_REGS];
  assign imm    = i_instr[BITS_INMEDIATE-1:0];
  assign target = i_instr[BITS_JUMP-1:0];
  // Opcode is decoded upstream; these bits are not needed here.
  assign unused_opcode = ^i_instr[BITS_SIZE-1:BITS_JUMP];

  // Bank read ports: r0 reads zero, and a same-cycle WB to a nonzero address
  // wins over the stored value (write-first).
  logic [BITS_SIZE-1:0] rs_data, rt_data;

  assign rs_data = (rs == '0) ? '0 :
                   (i_wb_reg_write && i_wb_addr_rd == rs) ? i_wb_data : regs_q[rs];
  assign rt_data = (rt == '0) ? '0 :
                   (i_wb_reg_write && i_wb_addr_rd == rt) ? i_wb_data : regs_q[rt];
  assign o_debug_data = (i_debug_addr == '0) ? '0 :
                        (i_wb_reg_write && i_wb_addr_rd == i_debug_addr) ? i_wb_data
                                                                         : regs_q[i_debug_addr];

  // Immediate extension
  logic [BITS_SIZE-1:0] sign_imm, branch_off, ext_imm;

  assign sign_imm   = {{EXT_W{imm[BITS_INMEDIATE-1]}}, imm};
  assign branch_off = {sign_imm[BITS_SIZE-3:0], 2'b00};

  always_comb begin
    ext_imm = sign_imm;
    unique case (i_ext_mode)
      2'd0: ext_imm = sign_imm;
      2'd1: ext_imm = {{EXT_W{1'b0}}, imm};
      2'd2: ext_imm = {imm, {EXT_W{1'b0}}};
      2'd3: ext_imm = branch_off;
      default: ext_imm = sign_imm;
    endcase
  end

  assign o_jump_target   = {i_pc4[BITS_SIZE-1 -: PC_HI_W], target, 2'b00};
  assign o_branch_target = i_pc4 + branch_off;

  // Hazards: both cases need the instruction in EX to target one of our
  // source registers. A load's data is not ready until after MEM. A branch
  // compares in ID, so any in-flight ALU result it reads is also too late.
  logic ex_rd_hit, haz_load_use, haz_branch;

  assign ex_rd_hit    = ex_q.valid && (ex_q.rd != '0) && (ex_q.rd == rs || ex_q.rd == rt);
  assign haz_load_use = ex_rd_hit && ex_q.mem_read;
  assign haz_branch   = (i_ctrl_beq || i_ctrl_bne) && ex_rd_hit && ex_q.reg_write;
  assign o_stall      = i_valid && (haz_load_use || haz_branch);

  assign o_branch_taken = i_valid && !o_stall &&
                          ((i_ctrl_beq && (rs_data == rt_data)) ||
                           (i_ctrl_bne && (rs_data != rt_data)));

  // ID/EX and stall counter next state
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (i_step) begin
      if (i_flush || o_stall || !i_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.mem_read  = i_ctrl_mem_read;
        ex_d.reg_write = i_ctrl_reg_write;
        ex_d.rs_data   = rs_data;
        ex_d.rt_data   = rt_data;
        ex_d.imm       = ext_imm;
        ex_d.pc4       = i_pc4;
        ex_d.rs        = rs;
        ex_d.rt        = rt;
        ex_d.rd        = i_ctrl_reg_dst ? rd : rt;
      end
      if (o_stall && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Bank writes ignore i_step so writeback is never lost during a freeze.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_wb_reg_write && i_wb_addr_rd != '0) begin
      regs_q[i_wb_addr_rd] <= i_wb_data;
    end
  end

  assign o_ex_valid     = ex_q.valid;
  assign o_ex_mem_read  = ex_q.mem_read;
  assign o_ex_reg_write = ex_q.reg_write;
  assign o_ex_rs_data   = ex_q.rs_data;
  assign o_ex_rt_data   = ex_q.rt_data;
  assign o_ex_imm       = ex_q.imm;
  assign o_ex_pc4       = ex_q.pc4;
  assign o_ex_rs        = ex_q.rs;
  assign o_ex_rt        = ex_q.rt;
  assign o_ex_rd        = ex_q.rd;
  assign o_stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
module tb_id_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [1:0]  ext_mode;
  logic        mem_read, reg_write, reg_dst, beq, bne, flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        stall, br_taken;
  logic [31:0] br_target, j_target;
  logic        ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ext_exp [4];

  // Clock / reset
  always #5 clk = ~clk;

  id_decode_pipe dut (
    .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_valid(valid),
    .i_instr(instr), .i_pc4(pc4), .i_ext_mode(ext_mode),
    .i_ctrl_mem_read(mem_read), .i_ctrl_reg_write(reg_write),
    .i_ctrl_reg_dst(reg_dst), .i_ctrl_beq(beq), .i_ctrl_bne(bne),
    .i_flush(flush), .i_wb_reg_write(wb_we), .i_wb_addr_rd(wb_addr),
    .i_wb_data(wb_data), .i_debug_addr(dbg_addr), .o_debug_data(dbg_data),
    .o_stall(stall), .o_branch_taken(br_taken), .o_branch_target(br_target),
    .o_jump_target(j_target), .o_ex_valid(ex_valid), .o_ex_mem_read(ex_mem_read),
    .o_ex_reg_write(ex_reg_write), .o_ex_rs_data(ex_rs_data),
    .o_ex_rt_data(ex_rt_data), .o_ex_imm(ex_imm), .o_ex_pc4(ex_pc4),
    .o_ex_rs(ex_rs), .o_ex_rt(ex_rt), .o_ex_rd(ex_rd), .o_stall_count(stall_count)
  );

  // Driver helpers
  function automatic logic [31:0] mk_i(input logic [4:0] s, input logic [4:0] t,
                                       input logic [15:0] im);
    return {6'h00, s, t, im};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d);
    return {6'h00, s, t, d, 11'h000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step = 1'b1; valid = 1'b0; instr = '0; ext_mode = 2'd0;
    mem_read = 1'b0; reg_write = 1'b0; reg_dst = 1'b0; beq = 1'b0; bne = 1'b0;
    flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ext_exp[0] = 32'hFFFF8001;
    ext_exp[1] = 32'h00008001;
    ext_exp[2] = 32'h80010000;
    ext_exp[3] = 32'hFFFE0004;

    idle(); pc4 = '0; dbg_addr = '0; rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset: seed R5 and an ID/EX entry, then reset with a WB also pending.
    wb(5'd5, 32'h1234);
    valid = 1'b1; instr = mk_r(5'd0, 5'd0, 5'd3); reg_write = 1'b1; reg_dst = 1'b1;
    pc4 = 32'h44;
    tick();
    idle(); dbg_addr = 5'd5; #1;
    check("seed_r5", dbg_data, 32'h1234);
    check("seed_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("seed_ex_pc4", ex_pc4, 32'h44);
    rst_n = 1'b0; wb(5'd6, 32'h77);
    tick();
    idle(); #1;
    check("rst_r5", dbg_data, 32'h0);
    dbg_addr = 5'd6; #1;
    check("rst_prio_r6", dbg_data, 32'h0);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ex_reg_write", {31'b0, ex_reg_write}, 32'd0);
    check("rst_ex_pc4", ex_pc4, 32'h0);
    check("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
    check("rst_stall_count", {16'b0, stall_count}, 32'd0);
    rst_n = 1'b1;

    // Bypass: WB R3 while decoding rs=3
    wb(5'd3, 32'hDEADBEEF);
    valid = 1'b1; instr = mk_r(5'd3, 5'd0, 5'd7); reg_write = 1'b1; reg_dst = 1'b1;
    pc4 = 32'h10; dbg_addr = 5'd3; #1;
    check("byp_debug", dbg_data, 32'hDEADBEEF);
    tick();
    idle(); #1;
    check("byp_ex_rs_data", ex_rs_data, 32'hDEADBEEF);
    check("byp_ex_rt_data", ex_rt_data, 32'h0);
    check("byp_ex_rd", {27'b0, ex_rd}, 32'd7);
    check("byp_ex_imm", ex_imm, 32'h3800);
    check("byp_ex_pc4", ex_pc4, 32'h10);
    check("byp_r3_stored", dbg_data, 32'hDEADBEEF);
    wb(5'd0, 32'h55); dbg_addr = 5'd0; #1;
    check("r0_bypass", dbg_data, 32'h0);
    tick();
    idle(); #1;
    check("r0_stored", dbg_data, 32'h0);

    // Load-use: lw R2, then add rs=2
    valid = 1'b1; instr = mk_i(5'd0, 5'd2, 16'h0004);
    mem_read = 1'b1; reg_write = 1'b1; reg_dst = 1'b0;
    tick();
    instr = mk_r(5'd2, 5'd0, 5'd6); mem_read = 1'b0; reg_write = 1'b1; reg_dst = 1'b1; #1;
    check("lu_ex_mem_read", {31'b0, ex_mem_read}, 32'd1);
    check("lu_ex_rd", {27'b0, ex_rd}, 32'd2);
    check("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble_mem_read", {31'b0, ex_mem_read}, 32'd0);
    check("lu_stall_clear", {31'b0, stall}, 32'd0);
    check("lu_stall_count", {16'b0, stall_count}, 32'd1);
    tick();
    idle(); #1;
    check("lu_issue_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_issue_rs", {27'b0, ex_rs}, 32'd2);
    check("lu_issue_rd", {27'b0, ex_rd}, 32'd6);
    check("lu_count_hold", {16'b0, stall_count}, 32'd1);

    // Branch resolution with R1 = R4 = 7
    wb(5'd1, 32'd7); tick();
    wb(5'd4, 32'd7); tick();
    idle();
    valid = 1'b1; beq = 1'b1; instr = mk_i(5'd1, 5'd4, 16'hFFFF);
    pc4 = 32'h100; ext_mode = 2'd3; #1;
    check("beq_taken", {31'b0, br_taken}, 32'd1);
    check("beq_target", br_target, 32'hFC);
    check("beq_no_stall", {31'b0, stall}, 32'd0);
    beq = 1'b0; bne = 1'b1; #1;
    check("bne_not_taken", {31'b0, br_taken}, 32'd0);
    idle(); tick();

    // Branch-operand hazard: ALU producer of R1 in EX
    valid = 1'b1; instr = mk_i(5'd0, 5'd1, 16'h0000); reg_write = 1'b1;
    tick();
    idle();
    valid = 1'b1; beq = 1'b1; instr = mk_i(5'd1, 5'd4, 16'hFFFF); pc4 = 32'h100; #1;
    check("brh_stall", {31'b0, stall}, 32'd1);
    check("brh_not_taken", {31'b0, br_taken}, 32'd0);
    tick();
    check("brh_stall_clear", {31'b0, stall}, 32'd0);
    check("brh_taken", {31'b0, br_taken}, 32'd1);
    check("brh_bubble", {31'b0, ex_valid}, 32'd0);
    check("brh_stall_count", {16'b0, stall_count}, 32'd2);
    idle(); tick();

    // Flush together with a load-use stall
    valid = 1'b1; instr = mk_i(5'd0, 5'd2, 16'h0008); mem_read = 1'b1; reg_write = 1'b1;
    tick();
    idle();
    valid = 1'b1; instr = mk_r(5'd2, 5'd0, 5'd6); reg_write = 1'b1; reg_dst = 1'b1;
    flush = 1'b1; #1;
    check("fl_stall", {31'b0, stall}, 32'd1);
    tick();
    idle(); #1;
    check("fl_bubble", {31'b0, ex_valid}, 32'd0);
    check("fl_stall_count", {16'b0, stall_count}, 32'd3);

    // Extension modes and jump target
    for (int m = 0; m < 4; m++) begin
      idle();
      valid = 1'b1; instr = mk_i(5'd0, 5'd0, 16'h8001); ext_mode = m[1:0]; pc4 = 32'h40;
      tick();
      check($sformatf("ext_mode%0d", m), ex_imm, ext_exp[m]);
    end
    idle();
    instr = 32'h03FFFFFF; pc4 = 32'hA0000000; #1;
    check("jump_target", j_target, 32'hAFFFFFFC);

    // Step freeze: WB lands, ID/EX holds
    step = 1'b0; valid = 1'b1; instr = mk_r(5'd9, 5'd0, 5'd5);
    reg_write = 1'b1; reg_dst = 1'b1; pc4 = 32'h200;
    wb(5'd9, 32'd5); dbg_addr = 5'd9;
    tick();
    wb_we = 1'b0; #1;
    check("frz_ex_imm", ex_imm, 32'hFFFE0004);
    check("frz_ex_pc4", ex_pc4, 32'h40);
    check("frz_ex_rs", {27'b0, ex_rs}, 32'd0);
    check("frz_debug_r9", dbg_data, 32'd5);
    check("frz_stall_count", {16'b0, stall_count}, 32'd3);
    step = 1'b1;
    tick();
    idle(); #1;
    check("step_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("step_ex_rs_data", ex_rs_data, 32'd5);
    check("step_ex_rs", {27'b0, ex_rs}, 32'd9);
    check("step_ex_pc4", ex_pc4, 32'h200);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
